// File: rtl/gate_bist_ctrl_if.sv
// Handshake/status bundle between the BIST sequencer and the board side:
// start button, gate-under-test wiring and status outputs.
interface gate_bist_ctrl_if #(
  parameter int WIDTH = 2
);
  logic             start;
  logic             dut_out;
  logic [WIDTH-1:0] vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   fail_count;
  logic [WIDTH-1:0] first_fail;

  modport master (
    output start, dut_out,
    input  vec_out, busy, done, pass, fail_count, first_fail
  );

  modport slave (
    input  start, dut_out,
    output vec_out, busy, done, pass, fail_count, first_fail
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive BIST sequencer for a WIDTH-input reduction gate (OR/AND/XOR golden).
// Optional macro GATE_BIST_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module gate_bist_ctrl #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int OP     = 0
) (
  input  logic          clk,
  input  logic          reset,
  gate_bist_ctrl_if.slave bist
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE);
  localparam logic [WIDTH-1:0] VEC_LAST  = '1;
  localparam logic [WIDTH:0]   FAIL_MAX  = (WIDTH+1)'(1) << WIDTH;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_vec;
  logic [WIDTH:0]   r_fail;
  logic [WIDTH-1:0] r_first;
  logic             r_busy;
  logic             r_done;

  logic w_golden;
  logic w_mismatch;

  if (OP == 1) begin : g_and
    assign w_golden = &r_vec;
  end else if (OP == 2) begin : g_xor
    assign w_golden = ^r_vec;
  end else begin : g_or
    assign w_golden = |r_vec;
  end

  assign w_mismatch = (bist.dut_out != w_golden);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_fail  <= '0;
      r_first <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Status flags follow the state one cycle later, matching the board timing.
      r_busy <= (r_state == S_SETTLE) || (r_state == S_CHECK);
      r_done <= (r_state == S_DONE);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (bist.start) begin
            r_vec   <= '0;
            r_fail  <= '0;
            r_first <= '0;
            r_cnt   <= SETTLE_LD;
            r_state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (r_cnt == CW'(1)) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            if (r_fail != FAIL_MAX) begin
              r_fail <= r_fail + (WIDTH+1)'(1);
            end
            if (r_fail == '0) begin
              r_first <= r_vec;
            end
          end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
          if (w_mismatch || (r_vec == VEC_LAST)) begin
            r_state <= S_DONE;
          end else begin
            r_vec   <= r_vec + WIDTH'(1);
            r_cnt   <= SETTLE_LD;
            r_state <= S_SETTLE;
          end
`else
          if (r_vec == VEC_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_vec   <= r_vec + WIDTH'(1);
            r_cnt   <= SETTLE_LD;
            r_state <= S_SETTLE;
          end
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bist.vec_out    = r_vec;
  assign bist.busy       = r_busy;
  assign bist.done       = r_done;
  assign bist.fail_count = r_fail;
  assign bist.first_fail = r_first;
  assign bist.pass       = r_done && (r_fail == '0);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomized self-checking bench for gate_bist_ctrl: a truth-table gate model
// drives dut_out, and expected results come from a per-vector count over the table.
module tb_gate_bist_ctrl;

  localparam int W  = 2;
  localparam int S  = 1;
  localparam int OP = 0;
  localparam int NV = 1 << W;

  logic clk = 1'b0;
  logic reset;
  logic [NV-1:0] gate_tt;

  int n_checks = 0;
  int n_pass   = 0;

  gate_bist_ctrl_if #(.WIDTH(W)) bif ();

  gate_bist_ctrl #(.WIDTH(W), .SETTLE(S), .OP(OP)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bist  (bif.slave)
  );

  always #5 clk = ~clk;

  // Gate under test: arbitrary truth table indexed by the driven vector.
  assign bif.dut_out = gate_tt[bif.vec_out];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic golden(input int v);
    int ones;
    ones = 0;
    for (int b = 0; b < W; b++) ones += (v >> b) & 1;
    case (OP)
      1:       return (ones == W);
      2:       return (ones % 2) == 1;
      default: return (ones > 0);
    endcase
  endfunction

  function automatic logic [NV-1:0] golden_table();
    logic [NV-1:0] t;
    for (int v = 0; v < NV; v++) t[v] = golden(v);
    return t;
  endfunction

  // Start at the next edge (edge 0), optionally re-pulse start on edges in
  // extra_mask, then track busy/done until done rises and compare results.
  task automatic run_bist(input string tag, input logic [NV-1:0] tt, input logic [31:0] extra_mask);
    int nfail, first, exp_done, exp_fail, exp_vec, done_edge, busy_err, lim;
    gate_tt = tt;
    nfail = 0;
    first = -1;
    for (int v = 0; v < NV; v++) begin
      if (tt[v] != golden(v)) begin
        nfail++;
        if (first < 0) first = v;
      end
    end
    exp_done = NV * (S + 1) + 1;
    exp_fail = nfail;
    exp_vec  = NV - 1;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    if (nfail > 0) begin
      exp_done = (first + 1) * (S + 1) + 1;
      exp_fail = 1;
      exp_vec  = first;
    end
`endif
    if (first < 0) first = 0;

    bif.start = 1'b1;
    @(posedge clk);
    #1;
    done_edge = 0;
    busy_err  = 0;
    lim       = exp_done + 4;
    for (int n = 1; n <= lim && done_edge == 0; n++) begin
      bif.start = (n < 32) ? extra_mask[n] : 1'b0;
      @(posedge clk);
      #1;
      if (bif.done) done_edge = n;
      if (n <= exp_done && bif.busy !== (n < exp_done)) busy_err++;
    end
    bif.start = 1'b0;

    check_val({tag, ".done_edge"},  done_edge,          exp_done);
    check_val({tag, ".busy"},       busy_err,           0);
    check_val({tag, ".fail_count"}, 32'(bif.fail_count), exp_fail);
    check_val({tag, ".first_fail"}, 32'(bif.first_fail), first);
    check_val({tag, ".vec_out"},    32'(bif.vec_out),    exp_vec);
    check_val({tag, ".pass"},       32'(bif.pass),       32'(exp_fail == 0 && done_edge != 0));
    $display("run %s: tt=%0h done@%0d fail_count=%0d first_fail=%0h pass=%0b",
             tag, tt, done_edge, bif.fail_count, bif.first_fail, bif.pass);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".busy"},       32'(bif.busy),       0);
    check_val({tag, ".done"},       32'(bif.done),       0);
    check_val({tag, ".pass"},       32'(bif.pass),       0);
    check_val({tag, ".vec_out"},    32'(bif.vec_out),    0);
    check_val({tag, ".fail_count"}, 32'(bif.fail_count), 0);
    check_val({tag, ".first_fail"}, 32'(bif.first_fail), 0);
  endtask

  initial begin
    logic [NV-1:0] good_tt;
    logic [NV-1:0] and_tt;
    logic [NV-1:0] rnd_tt;
    logic [31:0]   mask;

    good_tt = golden_table();
    for (int v = 0; v < NV; v++) and_tt[v] = (v == NV - 1);

    bif.start = 1'b0;
    gate_tt   = good_tt;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("idle");

    run_bist("good", good_tt, 32'h0);
    run_bist("stuck0", '0, 32'h0);
    run_bist("and_wired", and_tt, 32'h0);
    // Start pulses while busy are ignored; back-to-back run restarts from DONE.
    run_bist("busy_start", good_tt, 32'h48);
    run_bist("restart", good_tt, 32'h0);

    // Abort a good run with reset sampled at edge 4.
    gate_tt   = good_tt;
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("abort_e4");
    @(posedge clk);
    #1;
    check_all_zero("abort_e5");
    run_bist("after_abort", good_tt, 32'h0);

    for (int r = 0; r < 12; r++) begin
      rnd_tt = NV'($urandom) ^ (($urandom_range(0, 3) == 0) ? good_tt : '0);
      mask   = 32'($urandom) & 32'h7E & ((32'h1 << (NV * (S + 1) - 1)) - 1);
      run_bist($sformatf("rand%0d", r), rnd_tt, mask);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
